// File: rtl/nco_sweep_ctrl.sv
// Sequencer for a phase-increment NCO: flushes and primes the core, then steps
// phi_inc through a clamped linear up-sweep with per-step dwell and optional looping.
module nco_sweep_ctrl #(
  parameter int PHI_W         = 32,
  parameter int DWELL_W       = 16,
  parameter int FLUSH_CYC     = 2,
  parameter int PRIME_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PHI_W-1:0]   cfg_phi_start,
  input  logic [PHI_W-1:0]   cfg_phi_stop,
  input  logic [PHI_W-1:0]   cfg_phi_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               nco_out_valid,
  output logic [PHI_W-1:0]   nco_phi_inc_o,
  output logic               nco_clken_o,
  output logic               nco_reset_n_o,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               sweep_valid,
  output logic [15:0]        step_idx
);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_PRIME, S_RUN, S_DONE} state_t;

  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYC - 1);
  localparam logic [15:0] PRIME_LAST = 16'(PRIME_TIMEOUT - 1);

  state_t             state;
  logic [PHI_W-1:0]   sh_start;
  logic [PHI_W-1:0]   sh_stop;
  logic [PHI_W-1:0]   sh_step;
  logic [DWELL_W-1:0] sh_dwell_m1;
  logic               sh_loop;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [15:0]        tmr;
  logic               accept;

  // Next phase increment, saturating at the stop value (including carry out of PHI_W).
  function automatic logic [PHI_W-1:0] sat_step(input logic [PHI_W-1:0] phi,
                                                input logic [PHI_W-1:0] step,
                                                input logic [PHI_W-1:0] lim);
    logic [PHI_W:0] sum;
    sum = {1'b0, phi} + {1'b0, step};
    if (sum[PHI_W] || (sum[PHI_W-1:0] > lim))
      return lim;
    return sum[PHI_W-1:0];
  endfunction

  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  assign accept      = (state == S_IDLE) && start && !abort && (cfg_phi_start <= cfg_phi_stop);
  assign sweep_valid = (state == S_RUN) && nco_out_valid;

  // Shadow copy of the configuration, frozen for the whole sweep
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_start    <= cfg_phi_start;
      sh_stop     <= cfg_phi_stop;
      sh_step     <= cfg_phi_step;
      sh_dwell_m1 <= dwell_reload(cfg_dwell);
      sh_loop     <= cfg_loop;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      nco_phi_inc_o <= '0;
      nco_clken_o   <= 1'b0;
      nco_reset_n_o <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      step_idx      <= '0;
      tmr           <= '0;
      dwell_cnt     <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state         <= S_IDLE;
        nco_clken_o   <= 1'b0;
        nco_reset_n_o <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              if (cfg_phi_start > cfg_phi_stop) begin
                cfg_err <= 1'b1;
              end else begin
                state         <= S_FLUSH;
                busy          <= 1'b1;
                nco_phi_inc_o <= cfg_phi_start;
                step_idx      <= '0;
                tmr           <= '0;
              end
            end
          end
          S_FLUSH: begin
            if (tmr == FLUSH_LAST) begin
              state         <= S_PRIME;
              nco_reset_n_o <= 1'b1;
              nco_clken_o   <= 1'b1;
              tmr           <= '0;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end
          S_PRIME: begin
            if (nco_out_valid) begin
              state     <= S_RUN;
              dwell_cnt <= sh_dwell_m1;
            end else if (tmr == PRIME_LAST) begin
              state         <= S_IDLE;
              cfg_err       <= 1'b1;
              busy          <= 1'b0;
              nco_reset_n_o <= 1'b0;
              nco_clken_o   <= 1'b0;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end
          S_RUN: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else if (nco_phi_inc_o == sh_stop) begin
              if (sh_loop) begin
                nco_phi_inc_o <= sh_start;
                step_idx      <= '0;
                dwell_cnt     <= sh_dwell_m1;
              end else begin
                state         <= S_DONE;
                done          <= 1'b1;
                nco_clken_o   <= 1'b0;
                nco_reset_n_o <= 1'b0;
              end
            end else begin
              nco_phi_inc_o <= sat_step(nco_phi_inc_o, sh_step, sh_stop);
              step_idx      <= step_idx + 16'd1;
              dwell_cnt     <= sh_dwell_m1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: a stub NCO plus a scoreboard of expected
// (phi, step_idx) pairs consumed on every qualified RUN sample.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [31:0] cfg_phi_start, cfg_phi_stop, cfg_phi_step;
  logic [15:0] cfg_dwell;
  logic        cfg_loop;
  logic        nco_out_valid;
  logic [31:0] nco_phi_inc_o;
  logic        nco_clken_o, nco_reset_n_o, busy, done, cfg_err, sweep_valid;
  logic [15:0] step_idx;

  nco_sweep_ctrl #(.PHI_W(32), .DWELL_W(16), .FLUSH_CYC(2), .PRIME_TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_phi_start(cfg_phi_start), .cfg_phi_stop(cfg_phi_stop), .cfg_phi_step(cfg_phi_step),
    .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .nco_out_valid(nco_out_valid),
    .nco_phi_inc_o(nco_phi_inc_o), .nco_clken_o(nco_clken_o), .nco_reset_n_o(nco_reset_n_o),
    .busy(busy), .done(done), .cfg_err(cfg_err), .sweep_valid(sweep_valid), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // Stub NCO: out_valid rises 3 cycles after its reset is released
  logic       stub_en = 1'b1;
  logic [1:0] stub_cnt = 2'd0;
  always_ff @(posedge clk) begin
    if (!nco_reset_n_o) stub_cnt <= 2'd0;
    else if (stub_cnt != 2'd3) stub_cnt <= stub_cnt + 2'd1;
  end
  assign nco_out_valid = stub_en && nco_reset_n_o && (stub_cnt == 2'd3);

  logic [31:0] exp_phi_q[$];
  logic [15:0] exp_idx_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt, flush_cnt, run_cnt;
  bit released;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (sweep_valid) begin
      run_cnt++;
      checks++;
      assert (exp_phi_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed phi=0x%0h idx=%0d expected no sample", nco_phi_inc_o, step_idx);
      end
      if (exp_phi_q.size() != 0) begin
        chk("sb_phi", nco_phi_inc_o, exp_phi_q.pop_front());
        chk("sb_idx", step_idx, exp_idx_q.pop_front());
      end
    end
    if (done) done_cnt++;
    if (nco_reset_n_o) released = 1'b1;
    else if (busy && !released) flush_cnt++;
  endtask

  task automatic push_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            input logic [15:0] d, input int passes);
    logic [32:0] nxt;
    logic [31:0] p;
    logic [15:0] idx;
    int dd;
    dd = (d == 16'd0) ? 1 : int'(d);
    for (int k = 0; k < passes; k++) begin
      p = s;
      idx = 16'd0;
      while (1'b1) begin
        for (int j = 0; j < dd; j++) begin
          exp_phi_q.push_back(p);
          exp_idx_q.push_back(idx);
        end
        if (p == e) break;
        nxt = {1'b0, p} + {1'b0, st};
        p = (nxt > {1'b0, e}) ? e : nxt[31:0];
        idx = idx + 16'd1;
      end
    end
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input logic [15:0] d, input logic lp);
    cfg_phi_start = s; cfg_phi_stop = e; cfg_phi_step = st; cfg_dwell = d; cfg_loop = lp;
  endtask

  task automatic begin_sweep();
    done_cnt = 0; flush_cnt = 0; run_cnt = 0; released = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done_and_check(input string tag, input logic [31:0] e);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cyc();
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_phi_at_done"}, nco_phi_inc_o, e);
    chk({tag, "_rst_at_done"}, nco_reset_n_o, 0);
    cyc();
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_flush_cyc"}, flush_cnt, 2);
    chk({tag, "_sb_empty"}, exp_phi_q.size(), 0);
  endtask

  task automatic do_sweep(input string tag, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] st, input logic [15:0] d);
    set_cfg(s, e, st, d, 1'b0);
    push_sweep(s, e, st, d, 1);
    begin_sweep();
    wait_done_and_check(tag, e);
  endtask

  task automatic wait_run(input int n);
    for (int i = 0; i < 300 && run_cnt < n; i++) cyc();
    chk("run_reached", run_cnt >= n, 1);
  endtask

  initial begin
    bit seen;
    int prime_cnt;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(32'h0, 32'h0, 32'h0, 16'd0, 1'b0);
    done_cnt = 0; flush_cnt = 0; run_cnt = 0; released = 1'b0;
    cyc(); cyc();
    chk("rst_phi", nco_phi_inc_o, 0);
    chk("rst_nco_rst", nco_reset_n_o, 0);
    chk("rst_clken", nco_clken_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", step_idx, 0);
    reset_n = 1'b1;
    cyc();

    do_sweep("basic", 32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4);
    do_sweep("clamp", 32'h02800000, 32'h02A00000, 32'h00180000, 16'd1);
    do_sweep("wrap",  32'hFFF00000, 32'hFFFFFFFF, 32'h00200000, 16'd1);
    do_sweep("dwell0", 32'h00000100, 32'h00000300, 32'h00000100, 16'd0);

    // Loop mode, then abort mid-RUN
    set_cfg(32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4, 1'b1);
    push_sweep(32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4, 3);
    begin_sweep();
    wait_run(30);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_nco_rst", nco_reset_n_o, 0);
    chk("abort_clken", nco_clken_o, 0);
    chk("abort_svalid", sweep_valid, 0);
    cyc();
    chk("abort_no_done", done_cnt, 0);
    exp_phi_q.delete(); exp_idx_q.delete();

    // Inverted range rejected
    set_cfg(32'h10, 32'h0F, 32'h1, 16'd1, 1'b0);
    begin_sweep();
    chk("inv_err", cfg_err, 1);
    chk("inv_busy", busy, 0);
    cyc();
    chk("inv_err_pulse", cfg_err, 0);
    chk("inv_busy2", busy, 0);

    // Prime timeout
    stub_en = 1'b0;
    set_cfg(32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4, 1'b0);
    begin_sweep();
    seen = 1'b0; prime_cnt = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      if (busy && nco_reset_n_o) prime_cnt++;
      if (cfg_err) seen = 1'b1;
    end
    chk("tmo_err_seen", seen, 1);
    chk("tmo_prime_cyc", prime_cnt, 64);
    chk("tmo_busy", busy, 0);
    chk("tmo_nco_rst", nco_reset_n_o, 0);
    stub_en = 1'b1;
    cyc();

    // start and abort together
    set_cfg(32'h100, 32'h200, 32'h100, 16'd1, 1'b0);
    abort = 1'b1;
    begin_sweep();
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_err", cfg_err, 0);
    cyc();
    chk("sa_busy2", busy, 0);

    // start and cfg changes during RUN are ignored
    set_cfg(32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4, 1'b0);
    push_sweep(32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4, 1);
    begin_sweep();
    wait_run(5);
    set_cfg(32'h0, 32'h00000100, 32'h1, 16'd7, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done_and_check("ign", 32'h02AF5C29);

    // Reset mid-RUN, then a clean sweep
    set_cfg(32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4, 1'b0);
    push_sweep(32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4, 1);
    begin_sweep();
    wait_run(6);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("mrst_phi", nco_phi_inc_o, 0);
    chk("mrst_clken", nco_clken_o, 0);
    chk("mrst_nco_rst", nco_reset_n_o, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", cfg_err, 0);
    chk("mrst_idx", step_idx, 0);
    exp_phi_q.delete(); exp_idx_q.delete();
    cyc();
    chk("mrst_no_done", done_cnt, 0);
    do_sweep("post_rst", 32'h028F5C29, 32'h02AF5C29, 32'h00100000, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives a 32-bit phase-increment NCO (lpm_nco-class core, ports phi_inc_i/clken/reset_n/out_valid).
It resets and primes the NCO, then steps phi_inc through a programmed linear up-sweep (start, stop, step, dwell), optionally looping.
It also qualifies the NCO sample stream for downstream capture.
It sits between the control/register interface and the NCO instance in the modulation datapath.

Parameters:
PHI_W, 32, phase-increment width (matches NCO phi_inc_i)
DWELL_W, 16, dwell counter width (cycles per frequency step)
FLUSH_CYC, 2, cycles NCO reset is held low before priming (≥1)
PRIME_TIMEOUT, 64, max cycles to wait for NCO out_valid after release

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a sweep (ignored unless IDLE)
abort  in  1  terminate sweep; return to IDLE
cfg_phi_start  in  PHI_W  first phase increment
cfg_phi_stop  in  PHI_W  final phase increment (unsigned, must be ≥ start)
cfg_phi_step  in  PHI_W  increment added per step
cfg_dwell  in  DWELL_W  cycles per step (0 treated as 1)
cfg_loop  in  1  1 = restart from start after stop dwell
nco_out_valid  in  1  NCO out_valid
nco_phi_inc_o  out  PHI_W  to NCO phi_inc_i
nco_clken_o  out  1  to NCO clken
nco_reset_n_o  out  1  to NCO reset_n
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal (non-loop) completion
cfg_err  out  1  one-cycle pulse: start rejected or prime timeout
sweep_valid  out  1  nco_out_valid qualified by RUN state (combinational AND)
step_idx  out  16  index of current step; 0 at sweep start, wraps mod 2^16

Behaviour:
- Synchronous reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - nco_phi_inc_o=0, nco_clken_o=0, nco_reset_n_o=0.
  - busy=0, done=0, cfg_err=0, step_idx=0.
  - Reset mid-sweep aborts immediately; no done.
- States: IDLE, FLUSH, PRIME, RUN, DONE.
- IDLE:
  - nco_reset_n_o=0, nco_clken_o=0.
  - On start=1 & abort=0:
    - If cfg_phi_start > cfg_phi_stop (unsigned): pulse cfg_err, stay IDLE.
    - Otherwise latch all cfg_* into shadow regs (cfg inputs ignored until next IDLE), set nco_phi_inc_o=cfg_phi_start, step_idx=0, go FLUSH.
- FLUSH:
  - nco_reset_n_o=0 for exactly FLUSH_CYC cycles, then go PRIME.
- PRIME:
  - nco_reset_n_o=1, nco_clken_o=1.
  - First cycle with nco_out_valid=1: go RUN.
  - If no valid after PRIME_TIMEOUT cycles: pulse cfg_err, go IDLE.
- RUN:
  - nco_clken_o=1. Dwell counter loads max(dwell,1)-1 on entry and after each step, and decrements each cycle.
  - Each phi value is held exactly max(dwell,1) RUN cycles.
  - At dwell expiry, if phi==stop:
    - loop=1: phi←start, step_idx←0.
    - loop=0: go DONE.
  - At dwell expiry, otherwise: phi←min(phi+step, stop), with the carry out of PHI_W counted as overshoot and clamped to stop. step_idx increments.
  - step=0 with start≠stop: phi is constant and the sweep runs until abort (defined behaviour, not an error).
- DONE:
  - One cycle. done=1, nco_clken_o=0, nco_reset_n_o=0, nco_phi_inc_o holds stop. Then IDLE.
- abort=1 in FLUSH/PRIME/RUN/DONE: next state IDLE, NCO reset/clken deasserted next cycle, done not pulsed.
- start and abort in the same IDLE cycle: abort wins.
- start while busy: ignored.
- sweep_valid = (state==RUN) & nco_out_valid. Pipeline latency from a phi change to the NCO output frequency is the consumer's concern.
- nco_phi_inc_o and all state outputs are registered; only sweep_valid is combinational.

Test Plan:
1. Basic sweep: start=0x028F5C29, step=0x00100000, stop=0x02AF5C29, dwell=4, loop=0. Stub NCO asserts out_valid 3 cycles after release.
   -> FLUSH 2 cycles, then PRIME. RUN shows phi 0x028F5C29×4, 0x029F5C29×4, 0x02AF5C29×4 with step_idx 0,1,2. done pulses exactly once, then busy=0.
2. Clamp: start=0x02800000, stop=0x02A00000, step=0x00180000, dwell=1.
   -> phi sequence 0x02800000, 0x02980000, 0x02A00000, then done.
   Wrap: start=0xFFF00000, stop=0xFFFFFFFF, step=0x00200000 -> second value 0xFFFFFFFF (carry clamped).
3. Loop plus abort: case-1 config with loop=1, run 30 RUN cycles.
   -> after the stop dwell, phi returns to 0x028F5C29 and step_idx to 0.
   Assert abort -> IDLE next cycle, nco_reset_n_o=0, no done.
4. Errors:
   - start=0x10, stop=0x0F -> cfg_err pulse, busy stays 0.
   - Valid config with stub holding out_valid=0 -> cfg_err after 64 PRIME cycles, IDLE.
5. Corner inputs:
   - dwell=0 behaves as dwell=1.
   - start+abort in the same cycle -> stays IDLE.
   - start pulsed during RUN is ignored.
   - Changing cfg_* during RUN has no effect.
6. Reset: assert reset_n=0 mid-RUN for 1 cycle -> all outputs at reset values next edge. A following start sweeps correctly from step 0.
